// File: rtl/pipeline_hazard_unit_pkg.sv
// rtl/pipeline_hazard_unit_pkg.sv - RV32I control-word types and hazard qualifiers
package pipeline_hazard_unit_pkg;

   typedef enum logic [6:0] {
      op_lui   = 7'b0110111,
      op_auipc = 7'b0010111,
      op_jal   = 7'b1101111,
      op_jalr  = 7'b1100111,
      op_br    = 7'b1100011,
      op_load  = 7'b0000011,
      op_store = 7'b0100011,
      op_imm   = 7'b0010011,
      op_reg   = 7'b0110011,
      op_csr   = 7'b1110011
   } rv32i_opcode;

   typedef enum logic [2:0] {
      alu_out,
      br_en,
      u_imm,
      lw,
      pc_plus4
   } regfilemux_sel_t;

   typedef struct packed {
      rv32i_opcode     opcode;
      logic [2:0]      funct3;
      logic [4:0]      rs1_id;
      logic [4:0]      rs2_id;
      logic [4:0]      rd_id;
      logic            load_regfile;
      regfilemux_sel_t regfile_mux_sel;
   } rv32i_control_word;

   typedef enum logic {
      RUN,
      MEM_STALL
   } hazard_state_t;

   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;

   function automatic logic uses_rs1(input rv32i_opcode op);
      return !(op inside {op_lui, op_auipc, op_jal});
   endfunction

   function automatic logic uses_rs2(input rv32i_opcode op);
      return op inside {op_br, op_store, op_reg};
   endfunction

   // Ops whose operands are consumed in ID, before the EX forwarding path exists.
   function automatic logic is_id_resolved(input rv32i_control_word c);
      return (c.opcode inside {op_br, op_jalr}) ||
             ((c.opcode inside {op_reg, op_imm}) && (c.funct3 inside {F3_SLT, F3_SLTU}));
   endfunction

   function automatic logic depends_on(input rv32i_control_word prod,
                                       input rv32i_control_word cons);
      logic hit1;
      logic hit2;
      hit1 = uses_rs1(cons.opcode) && (prod.rd_id == cons.rs1_id);
      hit2 = uses_rs2(cons.opcode) && (prod.rd_id == cons.rs2_id);
      return prod.load_regfile && (prod.rd_id != 5'd0) && (hit1 || hit2);
   endfunction

endpackage

// File: rtl/pipeline_hazard_unit_if.sv
// rtl/pipeline_hazard_unit_if.sv - pipeline/cache status in, stage load enables out
interface pipeline_hazard_unit_if;
   import pipeline_hazard_unit_pkg::*;

   rv32i_control_word id_ex_in_ctrl;
   rv32i_control_word id_ex_out_ctrl;
   rv32i_control_word ex_mem_out_ctrl;
   logic icache_read;
   logic icache_resp;
   logic dcache_read;
   logic dcache_write;
   logic dcache_resp;
   logic redirect;
   logic load_pc;
   logic load_if_id;
   logic load_id_ex;
   logic load_ex_mem;
   logic load_mem_wb;
   logic id_ex_bubble;
   logic if_id_flush;

   modport master (
      input  id_ex_in_ctrl, id_ex_out_ctrl, ex_mem_out_ctrl,
      input  icache_read, icache_resp, dcache_read, dcache_write, dcache_resp, redirect,
      output load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
      output id_ex_bubble, if_id_flush
   );

   modport slave (
      output id_ex_in_ctrl, id_ex_out_ctrl, ex_mem_out_ctrl,
      output icache_read, icache_resp, dcache_read, dcache_write, dcache_resp, redirect,
      input  load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
      input  id_ex_bubble, if_id_flush
   );

endinterface

// File: rtl/pipeline_hazard_unit_mem_stall_tracker.sv
// rtl/pipeline_hazard_unit_mem_stall_tracker.sv - cache-miss freeze FSM with per-cache done flags
module pipeline_hazard_unit_mem_stall_tracker
   import pipeline_hazard_unit_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic icache_read,
   input  logic icache_resp,
   input  logic dcache_read,
   input  logic dcache_write,
   input  logic dcache_resp,
   output logic mem_wait,
   output logic release_cycle
);

   hazard_state_t state_q, state_d;
   logic          i_done_q, i_done_d;
   logic          d_done_q, d_done_d;
   logic          d_req;
   logic          i_hit;
   logic          d_hit;

   always_comb begin
      d_req    = dcache_read | dcache_write;
      // A response only counts while its own request is up.
      i_hit    = icache_read & icache_resp;
      d_hit    = d_req & dcache_resp;
      mem_wait = (icache_read & ~icache_resp & ~i_done_q) |
                 (d_req & ~dcache_resp & ~d_done_q);
      release_cycle = (state_q == MEM_STALL) & ~mem_wait;
      state_d  = state_q;
      i_done_d = 1'b0;
      d_done_d = 1'b0;
      case (state_q)
         RUN: begin
            if (mem_wait) begin
               state_d  = MEM_STALL;
               i_done_d = i_hit;
               d_done_d = d_hit;
            end
         end
         MEM_STALL: begin
            if (mem_wait) begin
               i_done_d = i_done_q | i_hit;
               d_done_d = d_done_q | d_hit;
            end else begin
               state_d = RUN;
            end
         end
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= RUN;
         i_done_q <= 1'b0;
         d_done_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         i_done_q <= i_done_d;
         d_done_q <= d_done_d;
      end
   end

endmodule

// File: rtl/pipeline_hazard_unit.sv
// rtl/pipeline_hazard_unit.sv - stall/flush controller and perf counters for the 5-stage RV32I pipe
module pipeline_hazard_unit
   import pipeline_hazard_unit_pkg::*;
#(
   parameter int CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   pipeline_hazard_unit_if.master hz,
   output logic [CNT_WIDTH-1:0] stall_cycles,
   output logic [CNT_WIDTH-1:0] bubble_cycles,
   output logic [CNT_WIDTH-1:0] redirect_count
);

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   logic mem_wait;
   logic release_cycle;
   logic id_resolved;
   logic dep_ex;
   logic dep_mem;
   logic h1, h2, h3;
   logic bubble;
   logic unused_ctrl;

   logic [CNT_WIDTH-1:0] stall_cycles_q, stall_cycles_d;
   logic [CNT_WIDTH-1:0] bubble_cycles_q, bubble_cycles_d;
   logic [CNT_WIDTH-1:0] redirect_count_q, redirect_count_d;

   pipeline_hazard_unit_mem_stall_tracker u_tracker (
      .clk           (clk),
      .rst           (rst),
      .icache_read   (hz.icache_read),
      .icache_resp   (hz.icache_resp),
      .dcache_read   (hz.dcache_read),
      .dcache_write  (hz.dcache_write),
      .dcache_resp   (hz.dcache_resp),
      .mem_wait      (mem_wait),
      .release_cycle (release_cycle)
   );

   assign unused_ctrl = ^{hz.id_ex_in_ctrl, hz.id_ex_out_ctrl, hz.ex_mem_out_ctrl, release_cycle};

   always_comb begin
      id_resolved = is_id_resolved(hz.id_ex_in_ctrl);
      dep_ex      = depends_on(hz.id_ex_out_ctrl, hz.id_ex_in_ctrl);
      dep_mem     = depends_on(hz.ex_mem_out_ctrl, hz.id_ex_in_ctrl);
      h1 = dep_ex && (hz.id_ex_out_ctrl.opcode == op_load);
      // A br_en-sourced producer (slt/sltu) has its result ready early enough to forward into ID.
      h2 = id_resolved && dep_ex && (hz.id_ex_out_ctrl.opcode != op_lui) &&
           (hz.id_ex_out_ctrl.regfile_mux_sel != br_en);
      h3 = id_resolved && dep_mem && (hz.ex_mem_out_ctrl.opcode == op_load);
      bubble = h1 | h2 | h3;
   end

   always_comb begin
      hz.load_pc      = 1'b0;
      hz.load_if_id   = 1'b0;
      hz.load_id_ex   = 1'b0;
      hz.load_ex_mem  = 1'b0;
      hz.load_mem_wb  = 1'b0;
      hz.id_ex_bubble = 1'b0;
      hz.if_id_flush  = 1'b0;
      if (rst && !mem_wait) begin
         hz.load_id_ex  = 1'b1;
         hz.load_ex_mem = 1'b1;
         hz.load_mem_wb = 1'b1;
         if (bubble) begin
            // Redirect is dropped here: it was computed from stale operands.
            hz.id_ex_bubble = 1'b1;
         end else begin
            hz.load_pc     = 1'b1;
            hz.load_if_id  = 1'b1;
            hz.if_id_flush = hz.redirect;
         end
      end
   end

   always_comb begin
      stall_cycles_d   = stall_cycles_q;
      bubble_cycles_d  = bubble_cycles_q;
      redirect_count_d = redirect_count_q;
      if (mem_wait && (stall_cycles_q != CNT_MAX))
         stall_cycles_d = stall_cycles_q + CNT_ONE;
      if (hz.id_ex_bubble && (bubble_cycles_q != CNT_MAX))
         bubble_cycles_d = bubble_cycles_q + CNT_ONE;
      if (hz.if_id_flush && (redirect_count_q != CNT_MAX))
         redirect_count_d = redirect_count_q + CNT_ONE;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cycles_q   <= '0;
         bubble_cycles_q  <= '0;
         redirect_count_q <= '0;
      end else begin
         stall_cycles_q   <= stall_cycles_d;
         bubble_cycles_q  <= bubble_cycles_d;
         redirect_count_q <= redirect_count_d;
      end
   end

   assign stall_cycles   = stall_cycles_q;
   assign bubble_cycles  = bubble_cycles_q;
   assign redirect_count = redirect_count_q;

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// tb/tb_pipeline_hazard_unit.sv - directed bench for pipeline_hazard_unit
module tb_pipeline_hazard_unit;
   import pipeline_hazard_unit_pkg::*;

   localparam int CW = 4;
   localparam logic [6:0] RUN_ALL = 7'b1111100;
   localparam logic [6:0] BUB     = 7'b0011110;
   localparam logic [6:0] FLS     = 7'b1111101;
   localparam logic [6:0] FRZ     = 7'b0000000;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic [CW-1:0] stall_cycles, bubble_cycles, redirect_count;
   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   pipeline_hazard_unit_if hz();

   pipeline_hazard_unit #(.CNT_WIDTH(CW)) dut (
      .clk            (clk),
      .rst            (rst),
      .hz             (hz),
      .stall_cycles   (stall_cycles),
      .bubble_cycles  (bubble_cycles),
      .redirect_count (redirect_count)
   );

   wire [6:0] outs = {hz.load_pc, hz.load_if_id, hz.load_id_ex, hz.load_ex_mem,
                      hz.load_mem_wb, hz.id_ex_bubble, hz.if_id_flush};

   rv32i_control_word NOP, LW_X5, LW_X5_NOWE, LW_X0, ADD_X6_X5_X1, ADD_X6_X0_X1, BEQ_X5_X0;
   rv32i_control_word ADD_X7, BLT_X7_X2, LUI_X7, SLT_X7, SW_X5, ADDI_RS2_5, LUI_RS1_5;
   rv32i_control_word SLTI_X7, ADDI_X7, JALR_X5;

   function automatic rv32i_control_word cw(input rv32i_opcode op, input logic [2:0] f3,
                                            input logic [4:0] rd, input logic [4:0] rs1,
                                            input logic [4:0] rs2, input logic we,
                                            input regfilemux_sel_t sel);
      rv32i_control_word c;
      c.opcode = op; c.funct3 = f3; c.rd_id = rd; c.rs1_id = rs1; c.rs2_id = rs2;
      c.load_regfile = we; c.regfile_mux_sel = sel;
      return c;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_pipe(input rv32i_control_word id, input rv32i_control_word ex,
                           input rv32i_control_word mem);
      hz.id_ex_in_ctrl   = id;
      hz.id_ex_out_ctrl  = ex;
      hz.ex_mem_out_ctrl = mem;
   endtask

   task automatic idle();
      set_pipe(NOP, NOP, NOP);
      hz.icache_read = 1'b0; hz.icache_resp = 1'b0;
      hz.dcache_read = 1'b0; hz.dcache_write = 1'b0; hz.dcache_resp = 1'b0;
      hz.redirect = 1'b0;
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b0;
      step();
      rst = 1'b1;
      step();
   endtask

   task automatic test_reset();
      idle();
      set_pipe(ADD_X6_X5_X1, LW_X5, NOP);
      hz.redirect = 1'b1;
      rst = 1'b0;
      step(); #2;
      checks++; if (outs !== FRZ) begin errors++; $display("FAIL reset_outs: got %b want %b", outs, FRZ); end
      checks++; if ({stall_cycles, bubble_cycles, redirect_count} !== 12'h000) begin
         errors++; $display("FAIL reset_counters: got %h want 000", {stall_cycles, bubble_cycles, redirect_count}); end
      rst = 1'b1;
      step();
   endtask

   task automatic test_load_use();
      do_reset();
      set_pipe(ADD_X6_X5_X1, LW_X5, NOP); #2;
      checks++; if (outs !== BUB) begin errors++; $display("FAIL load_use_bubble: got %b want %b", outs, BUB); end
      step();
      set_pipe(ADD_X6_X5_X1, NOP, LW_X5); #2;
      checks++; if (outs !== RUN_ALL) begin errors++; $display("FAIL load_use_after: got %b want %b", outs, RUN_ALL); end
      checks++; if (bubble_cycles !== 4'd1) begin errors++; $display("FAIL load_use_count: got %0d want 1", bubble_cycles); end
      step();
   endtask

   task automatic test_load_branch();
      do_reset();
      hz.redirect = 1'b1;
      set_pipe(BEQ_X5_X0, LW_X5, NOP); #2;
      checks++; if (outs !== BUB) begin errors++; $display("FAIL ld_br_h1: got %b want %b", outs, BUB); end
      step();
      set_pipe(BEQ_X5_X0, NOP, LW_X5); #2;
      checks++; if (outs !== BUB) begin errors++; $display("FAIL ld_br_h3: got %b want %b", outs, BUB); end
      step();
      set_pipe(BEQ_X5_X0, NOP, NOP); #2;
      checks++; if (outs !== FLS) begin errors++; $display("FAIL ld_br_flush: got %b want %b", outs, FLS); end
      step();
      idle(); #2;
      checks++; if (outs !== RUN_ALL) begin errors++; $display("FAIL ld_br_idle: got %b want %b", outs, RUN_ALL); end
      checks++; if (bubble_cycles !== 4'd2) begin errors++; $display("FAIL ld_br_bubbles: got %0d want 2", bubble_cycles); end
      checks++; if (redirect_count !== 4'd1) begin errors++; $display("FAIL ld_br_redirects: got %0d want 1", redirect_count); end
   endtask

   task automatic test_alu_branch();
      do_reset();
      set_pipe(BLT_X7_X2, ADD_X7, NOP); #2;
      checks++; if (outs !== BUB) begin errors++; $display("FAIL alu_br_bubble: got %b want %b", outs, BUB); end
      step();
      set_pipe(BLT_X7_X2, NOP, ADD_X7); #2;
      checks++; if (outs !== RUN_ALL) begin errors++; $display("FAIL alu_br_second: got %b want %b", outs, RUN_ALL); end
      step();
      set_pipe(BLT_X7_X2, LUI_X7, NOP); #2;
      checks++; if (outs !== RUN_ALL) begin errors++; $display("FAIL lui_br: got %b want %b", outs, RUN_ALL); end
      step(); #2;
      checks++; if (bubble_cycles !== 4'd1) begin errors++; $display("FAIL alu_br_count: got %0d want 1", bubble_cycles); end
   endtask

   task automatic test_qualifiers();
      rv32i_control_word t_id[10], t_ex[10], t_mem[10];
      logic [6:0] t_exp[10];
      t_id[0] = SW_X5;        t_ex[0] = LW_X5;      t_mem[0] = NOP;   t_exp[0] = BUB;
      t_id[1] = ADDI_RS2_5;   t_ex[1] = LW_X5;      t_mem[1] = NOP;   t_exp[1] = RUN_ALL;
      t_id[2] = LUI_RS1_5;    t_ex[2] = LW_X5;      t_mem[2] = NOP;   t_exp[2] = RUN_ALL;
      t_id[3] = ADD_X6_X0_X1; t_ex[3] = LW_X0;      t_mem[3] = NOP;   t_exp[3] = RUN_ALL;
      t_id[4] = SLTI_X7;      t_ex[4] = ADD_X7;     t_mem[4] = NOP;   t_exp[4] = BUB;
      t_id[5] = ADDI_X7;      t_ex[5] = ADD_X7;     t_mem[5] = NOP;   t_exp[5] = RUN_ALL;
      t_id[6] = BLT_X7_X2;    t_ex[6] = SLT_X7;     t_mem[6] = NOP;   t_exp[6] = RUN_ALL;
      t_id[7] = JALR_X5;      t_ex[7] = NOP;        t_mem[7] = LW_X5; t_exp[7] = BUB;
      t_id[8] = ADD_X6_X5_X1; t_ex[8] = NOP;        t_mem[8] = LW_X5; t_exp[8] = RUN_ALL;
      t_id[9] = BEQ_X5_X0;    t_ex[9] = LW_X5_NOWE; t_mem[9] = NOP;   t_exp[9] = RUN_ALL;
      do_reset();
      for (int i = 0; i < 10; i++) begin
         set_pipe(t_id[i], t_ex[i], t_mem[i]); #2;
         checks++;
         if (outs !== t_exp[i]) begin
            errors++; $display("FAIL qualifier_%0d: got %b want %b", i, outs, t_exp[i]);
         end
         step();
      end
   endtask

   task automatic test_mem_stall();
      do_reset();
      hz.icache_read = 1'b1; hz.dcache_write = 1'b1;
      for (int c = 0; c < 6; c++) begin
         hz.icache_resp = (c == 3); hz.dcache_resp = (c == 5); #2;
         checks++;
         if (outs !== ((c < 5) ? FRZ : RUN_ALL)) begin
            errors++; $display("FAIL mem_stall_c%0d: got %b want %b", c, outs, (c < 5) ? FRZ : RUN_ALL);
         end
         step();
      end
      idle(); #2;
      checks++; if (stall_cycles !== 4'd5) begin errors++; $display("FAIL mem_stall_count: got %0d want 5", stall_cycles); end
      checks++; if (outs !== RUN_ALL) begin errors++; $display("FAIL mem_stall_after: got %b want %b", outs, RUN_ALL); end
   endtask

   task automatic test_simultaneous_resp();
      do_reset();
      set_pipe(ADD_X6_X5_X1, LW_X5, NOP);
      hz.icache_read = 1'b1; hz.dcache_read = 1'b1;
      for (int c = 0; c < 3; c++) begin
         hz.icache_resp = (c == 2); hz.dcache_resp = (c == 2); #2;
         checks++;
         if (outs !== ((c < 2) ? FRZ : BUB)) begin
            errors++; $display("FAIL simul_resp_c%0d: got %b want %b", c, outs, (c < 2) ? FRZ : BUB);
         end
         step();
      end
      idle(); #2;
      checks++; if (stall_cycles !== 4'd2) begin errors++; $display("FAIL simul_stall_count: got %0d want 2", stall_cycles); end
      checks++; if (bubble_cycles !== 4'd1) begin errors++; $display("FAIL simul_bubble_count: got %0d want 1", bubble_cycles); end
   endtask

   task automatic test_stray_resp();
      do_reset();
      hz.dcache_read = 1'b1; hz.icache_resp = 1'b1; #2;
      checks++; if (outs !== FRZ) begin errors++; $display("FAIL stray_c0: got %b want %b", outs, FRZ); end
      step();
      hz.icache_resp = 1'b0; hz.icache_read = 1'b1; hz.dcache_resp = 1'b1; #2;
      checks++; if (outs !== FRZ) begin errors++; $display("FAIL stray_c1: got %b want %b", outs, FRZ); end
      step();
      hz.dcache_resp = 1'b0; hz.icache_resp = 1'b1; #2;
      checks++; if (outs !== RUN_ALL) begin errors++; $display("FAIL stray_c2: got %b want %b", outs, RUN_ALL); end
      step();
      idle(); #2;
      checks++; if (stall_cycles !== 4'd2) begin errors++; $display("FAIL stray_count: got %0d want 2", stall_cycles); end
   endtask

   task automatic test_redirect_stall();
      do_reset();
      hz.redirect = 1'b1; hz.icache_read = 1'b1;
      for (int c = 0; c < 5; c++) begin
         hz.icache_resp = (c == 4); #2;
         checks++;
         if (outs !== ((c < 4) ? FRZ : FLS)) begin
            errors++; $display("FAIL redir_stall_c%0d: got %b want %b", c, outs, (c < 4) ? FRZ : FLS);
         end
         step();
      end
      idle(); #2;
      checks++; if (redirect_count !== 4'd1) begin errors++; $display("FAIL redir_stall_count: got %0d want 1", redirect_count); end
      checks++; if (stall_cycles !== 4'd4) begin errors++; $display("FAIL redir_stall_cycles: got %0d want 4", stall_cycles); end
   endtask

   task automatic test_saturation();
      do_reset();
      set_pipe(ADD_X6_X5_X1, LW_X5, NOP);
      repeat (14) step();
      #2;
      checks++; if (bubble_cycles !== 4'd14) begin errors++; $display("FAIL sat_mid: got %0d want 14", bubble_cycles); end
      repeat (6) step();
      #2;
      checks++; if (bubble_cycles !== 4'd15) begin errors++; $display("FAIL sat_hold: got %0d want 15", bubble_cycles); end
      idle();
      step();
   endtask

   task automatic test_async_reset_mid_stall();
      do_reset();
      hz.icache_read = 1'b1; hz.dcache_read = 1'b1;
      step();
      hz.icache_resp = 1'b1;
      step();
      hz.icache_resp = 1'b0; #2;
      checks++; if (outs !== FRZ) begin errors++; $display("FAIL arst_pre: got %b want %b", outs, FRZ); end
      #1 rst = 1'b0;
      #1;
      checks++; if (stall_cycles !== 4'd0) begin errors++; $display("FAIL arst_clear: got %0d want 0", stall_cycles); end
      checks++; if (outs !== FRZ) begin errors++; $display("FAIL arst_outs: got %b want %b", outs, FRZ); end
      hz.dcache_read = 1'b0;
      step();
      rst = 1'b1; #2;
      checks++; if (outs !== FRZ) begin errors++; $display("FAIL arst_idone_cleared: got %b want %b", outs, FRZ); end
      step();
      hz.icache_resp = 1'b1; #2;
      checks++; if (outs !== RUN_ALL) begin errors++; $display("FAIL arst_release: got %b want %b", outs, RUN_ALL); end
      step();
      idle(); #2;
      checks++; if (stall_cycles !== 4'd1) begin errors++; $display("FAIL arst_count: got %0d want 1", stall_cycles); end
   endtask

   initial begin
      NOP          = cw(op_imm,   3'b000, 5'd0, 5'd0, 5'd0, 1'b0, alu_out);
      LW_X5        = cw(op_load,  3'b010, 5'd5, 5'd1, 5'd0, 1'b1, lw);
      LW_X5_NOWE   = cw(op_load,  3'b010, 5'd5, 5'd1, 5'd0, 1'b0, lw);
      LW_X0        = cw(op_load,  3'b010, 5'd0, 5'd1, 5'd0, 1'b1, lw);
      ADD_X6_X5_X1 = cw(op_reg,   3'b000, 5'd6, 5'd5, 5'd1, 1'b1, alu_out);
      ADD_X6_X0_X1 = cw(op_reg,   3'b000, 5'd6, 5'd0, 5'd1, 1'b1, alu_out);
      BEQ_X5_X0    = cw(op_br,    3'b000, 5'd0, 5'd5, 5'd0, 1'b0, alu_out);
      ADD_X7       = cw(op_reg,   3'b000, 5'd7, 5'd3, 5'd4, 1'b1, alu_out);
      BLT_X7_X2    = cw(op_br,    3'b100, 5'd0, 5'd7, 5'd2, 1'b0, alu_out);
      LUI_X7       = cw(op_lui,   3'b000, 5'd7, 5'd0, 5'd0, 1'b1, u_imm);
      SLT_X7       = cw(op_reg,   3'b010, 5'd7, 5'd3, 5'd4, 1'b1, br_en);
      SW_X5        = cw(op_store, 3'b010, 5'd0, 5'd1, 5'd5, 1'b0, alu_out);
      ADDI_RS2_5   = cw(op_imm,   3'b000, 5'd6, 5'd1, 5'd5, 1'b1, alu_out);
      LUI_RS1_5    = cw(op_lui,   3'b000, 5'd6, 5'd5, 5'd0, 1'b1, u_imm);
      SLTI_X7      = cw(op_imm,   3'b010, 5'd6, 5'd7, 5'd0, 1'b1, br_en);
      ADDI_X7      = cw(op_imm,   3'b000, 5'd6, 5'd7, 5'd0, 1'b1, alu_out);
      JALR_X5      = cw(op_jalr,  3'b000, 5'd1, 5'd5, 5'd0, 1'b1, pc_plus4);

      test_reset();
      test_load_use();
      test_load_branch();
      test_alu_branch();
      test_qualifiers();
      test_mem_stall();
      test_simultaneous_resp();
      test_stray_resp();
      test_redirect_stall();
      test_saturation();
      test_async_reset_mid_stall();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
